reparam_sampler: RTL
====================

REPARAM_SAMPLER -- requirements
Module: reparam_sampler

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, initial LFSR state (value 0 replaced by 16'h0001).
REQ-002 SHALL have parameter W, default 16, data width; only 16 is supported.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  mu/sigma/det valid
- in_ready  output  1  block accepts input this cycle
- mu  input  16  latent mean, signed Q8.8
- sigma  input  16  std-dev from the softplus stage, signed Q8.8, expected >= 0
- det  input  1  deterministic mode: eps forced to 0, LFSR held
- out_valid  output  1  z valid
- out_ready  input  1  downstream accepts z
- z  output  16  sample mu + sigma*eps, signed Q8.8, saturated
- eps_out  output  16  eps used for this z, signed Q8.8 (debug/verification)

Function
REQ-004 SHALL accept a transfer when in_valid && in_ready; SHALL emit when out_valid && out_ready.
REQ-005 SHALL be a 3-stage pipeline: S1 capture mu/sigma/eps, S2 multiply, S3 add+saturate; latency 3 cycles from acceptance to out_valid when unstalled.
REQ-006 SHALL use a global advance enable en = !out_valid || out_ready; every stage register and valid bit updates only when en=1.
REQ-007 SHALL drive in_ready = en (combinational); with out_ready held high, throughput is one sample per cycle.
REQ-008 SHALL hold z, eps_out, out_valid stable while out_valid && !out_ready.
REQ-009 LFSR: 16-bit Galois, taps mask 16'hB400, shifts right, steps once per accepted input with det=0; does not step on det=1 or no acceptance.
REQ-010 eps (det=0) SHALL be computed from LFSR state before stepping: s = sum of its four nibbles (0..60); eps = (s - 30) * 28, range -840..+840 (approx N(0,1) in Q8.8).
REQ-011 det=1 SHALL give eps = 0, hence z = mu exactly.
REQ-012 Product p = sigma * eps as 32-bit signed; scaled product q = p >>> 8 (arithmetic, truncation toward -inf).
REQ-013 z = mu + q evaluated at 18+ bits, saturated to [16'h8000, 16'h7FFF].
REQ-014 Negative sigma SHALL be processed arithmetically as given, no clamping.
REQ-015 Simultaneous accept and emit in one cycle SHALL both occur; no bubble inserted.

Reset
REQ-016 On rst: out_valid=0, all internal valid bits=0, z=0, eps_out=0, LFSR=SEED (or 1 if SEED=0).
REQ-017 in_ready SHALL be 1 while rst is high and after deassertion; in-flight samples are discarded, none emitted after reset.
REQ-018 Reset mid-stream SHALL restart the eps sequence from SEED.

Structure
REQ-019 Shared package SHALL hold: Q8.8 FRAC_BITS=8, LFSR_TAPS=16'hB400, EPS_MEAN=30, EPS_SCALE=28, SAT_MAX/SAT_MIN.
REQ-020 One sub-module lfsr_gauss (LFSR state, step enable, eps output) SHALL be instantiated; pipeline and saturation live in reparam_sampler.

Verification
REQ-021 Det mode: mu=16'h0100, sigma=16'h0500, det=1, out_ready=1 -> z=16'h0100, eps_out=0 three cycles later; LFSR unchanged.
REQ-022 First random sample after reset, SEED=16'hACE1: mu=0, sigma=16'h0100, det=0 -> eps_out=16'h00C4 (nibbles 10+12+14+1=37), z=16'h00C4.
REQ-023 Saturation: mu=16'h7F00, sigma=16'h7FFF, first sample after reset -> q=25087, z=16'h7FFF; mirror with mu=16'h8100, sigma=16'h8001 -> z=16'h8000.
REQ-024 Backpressure: out_ready=0, in_valid=1 continuously -> exactly 3 accepts, then in_ready=0; z stable; releasing out_ready drains samples in order, no loss/duplication.
REQ-025 Reset mid-stream: assert rst with 2 samples in flight -> out_valid=0 immediately, none emitted; next sample reproduces REQ-022 values.
REQ-026 Random stream of 10k samples with sigma=16'h0100, mu=0 -> compare z to a reference model bit-exactly; sample mean within ±0.05, std within 1.0±0.1.

Source files
------------

// File: rtl/reparam_sampler_pkg.sv
// Shared constants and helpers for the reparameterisation sampler.
// Values are signed Q8.8; eps is an approximate N(0,1) built from LFSR nibbles.
package reparam_sampler_pkg;

    localparam int FRAC_BITS = 8;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int EPS_MEAN = 30;
    localparam int EPS_SCALE = 28;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // Sum of four uniform nibbles is roughly Gaussian; centre and scale it to Q8.8.
    function automatic logic signed [15:0] nibble_eps(input logic [15:0] state);
        int sum;
        int scaled;
        sum = int'(state[3:0]) + int'(state[7:4]) + int'(state[11:8]) + int'(state[15:12]);
        scaled = (sum - EPS_MEAN) * EPS_SCALE;
        return 16'(scaled);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] value);
        if (value > 32'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (value < 32'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return value[15:0];
        end
    endfunction

endpackage

// File: rtl/reparam_sampler_lfsr_gauss.sv
// Galois LFSR noise source; eps reflects the current state, the step applies afterwards.
module lfsr_gauss
    import reparam_sampler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_step,
    output logic signed [15:0] o_eps
);

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] INIT_STATE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_state;
    logic [15:0] w_next;

    always_comb begin
        w_next = {1'b0, r_state[15:1]};
        if (r_state[0]) begin
            w_next = w_next ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT_STATE;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_eps = nibble_eps(r_state);

endmodule

// File: rtl/reparam_sampler.sv
// Three-stage z = mu + sigma*eps sampler (capture, multiply, add+saturate)
// with a single global advance enable driven by downstream backpressure.
module reparam_sampler
    import reparam_sampler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] mu,
    input  logic [W-1:0] sigma,
    input  logic         det,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [W-1:0] eps_out
);

    logic               w_en;
    logic               w_accept;
    logic               w_step;
    logic signed [15:0] w_lfsr_eps;
    logic signed [15:0] w_eps;

    logic               r_v1;
    logic signed [15:0] r_mu1;
    logic signed [15:0] r_sig1;
    logic signed [15:0] r_eps1;

    logic               r_v2;
    logic signed [15:0] r_mu2;
    logic signed [15:0] r_eps2;
    logic signed [31:0] r_p2;

    logic               r_v3;
    logic signed [15:0] r_z3;
    logic signed [15:0] r_eps3;

    logic signed [31:0] w_prod;
    logic signed [31:0] w_mu_ext;
    logic signed [31:0] w_q;
    logic signed [31:0] w_sum;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign w_en     = !r_v3 || out_ready;
    assign in_ready = w_en;
    assign w_accept = in_valid && w_en;
    assign w_step   = w_accept && !det;

    lfsr_gauss #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_step (w_step),
        .o_eps  (w_lfsr_eps)
    );

    assign w_eps    = det ? 16'sh0000 : w_lfsr_eps;
    assign w_prod   = r_sig1 * r_eps1;
    assign w_mu_ext = {{16{r_mu2[15]}}, r_mu2};
    assign w_q      = r_p2 >>> FRAC_BITS;
    assign w_sum    = w_mu_ext + w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_mu1  <= '0;
            r_sig1 <= '0;
            r_eps1 <= '0;
            r_v2   <= 1'b0;
            r_mu2  <= '0;
            r_eps2 <= '0;
            r_p2   <= '0;
            r_v3   <= 1'b0;
            r_z3   <= '0;
            r_eps3 <= '0;
        end else if (w_en) begin
            r_v1   <= in_valid;
            r_mu1  <= mu;
            r_sig1 <= sigma;
            r_eps1 <= w_eps;
            r_v2   <= r_v1;
            r_mu2  <= r_mu1;
            r_eps2 <= r_eps1;
            r_p2   <= w_prod;
            r_v3   <= r_v2;
            r_z3   <= sat16(w_sum);
            r_eps3 <= r_eps2;
        end
    end

    assign out_valid = r_v3;
    assign z         = r_z3;
    assign eps_out   = r_eps3;

endmodule
